// File: rtl/sumitup_pkg.sv
// Shared types and helpers for the sumitup accumulator thread.
package sumitup_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    // Width needed to hold 0..max_cnt, never narrower than one bit.
    function automatic int cnt_w(input int max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/sumitup_acc_sat_add.sv
// Combinational SUM_W+1-bit add of accumulator and extended operand,
// with overflow detect and optional clamp to the SUM_W range.
module acc_sat_add #(
    parameter int IN_W      = 8,
    parameter int SUM_W     = 16,
    parameter bit SATURATE  = 1'b1,
    parameter bit SIGNED_IN = 1'b0
) (
    input  logic [SUM_W-1:0] acc,
    input  logic [IN_W-1:0]  operand,
    output logic [SUM_W-1:0] result,
    output logic             ovf
);

    localparam int PAD = SUM_W + 1 - IN_W;

    logic             op_fill;
    logic             acc_fill;
    logic [SUM_W:0]   op_x;
    logic [SUM_W:0]   acc_x;
    logic [SUM_W:0]   raw;

    assign op_fill  = SIGNED_IN & operand[IN_W-1];
    assign acc_fill = SIGNED_IN & acc[SUM_W-1];
    assign op_x     = {{PAD{op_fill}}, operand};
    assign acc_x    = {acc_fill, acc};
    assign raw      = acc_x + op_x;

    // Both addends fit SUM_W+1 bits, so the extra bit is exact: signed
    // overflow shows as disagreement between the top two bits.
    assign ovf = SIGNED_IN ? (raw[SUM_W] ^ raw[SUM_W-1]) : raw[SUM_W];

    always_comb begin
        result = raw[SUM_W-1:0];
        if (SATURATE && ovf) begin
            if (!SIGNED_IN)
                result = '1;
            else if (raw[SUM_W])
                result = {1'b1, {(SUM_W-1){1'b0}}};
            else
                result = {1'b0, {(SUM_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/sumitup_acc.sv
// Operand-stream accumulator: go_l starts a run, zero or MAX_CNT operands
// ends it, and the result is held with done until the downstream acks.
module sumitup_acc
    import sumitup_pkg::*;
#(
    parameter int  IN_W      = 8,
    parameter int  SUM_W     = 16,
    parameter int  MAX_CNT   = 255,
    parameter bit  SATURATE  = 1'b1,
    parameter bit  SIGNED_IN = 1'b0,
    localparam int CNT_W     = cnt_w(MAX_CNT)
) (
    input  logic             ck,
    input  logic             reset_l,
    input  logic             go_l,
    input  logic [IN_W-1:0]  inA,
    input  logic             ack,
    output logic [SUM_W-1:0] sum,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    acc_state_t       state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] add_result;
    logic             add_ovf;

    acc_sat_add #(
        .IN_W     (IN_W),
        .SUM_W    (SUM_W),
        .SATURATE (SATURATE),
        .SIGNED_IN(SIGNED_IN)
    ) u_add (
        .acc    (sum_q),
        .operand(inA),
        .result (add_result),
        .ovf    (add_ovf)
    );

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (!go_l) begin
                    state_d = RUN;
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (inA == '0) begin
                    state_d = HOLD;
                end else begin
                    sum_d   = add_result;
                    count_d = count_inc;
                    ovf_d   = ovf_q | add_ovf;
                    if (count_inc == CNT_W'(MAX_CNT))
                        state_d = HOLD;
                end
            end
            HOLD: begin
                // go_l only matters once the result has been taken
                if (ack) begin
                    if (go_l) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                        sum_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum   = sum_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign done  = (state_q == HOLD);
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_sumitup_acc.sv
// Directed bench for sumitup_acc: five configurations share one stimulus
// bus; each vector is checked against the configuration it targets.
module tb_sumitup_acc;

    logic       ck = 1'b0;
    logic       reset_l;
    logic       go_l;
    logic       ack;
    logic [7:0] inA;

    always #5 ck = ~ck;

    // 0: defaults  1: SUM_W=9 sat  2: SUM_W=9 wrap  3: MAX_CNT=4  4: signed 8/8 sat
    logic [15:0] sum0;  logic [7:0] cnt0;  logic done0, busy0, ovf0;
    logic [8:0]  sum1;  logic [7:0] cnt1;  logic done1, busy1, ovf1;
    logic [8:0]  sum2;  logic [7:0] cnt2;  logic done2, busy2, ovf2;
    logic [15:0] sum3;  logic [2:0] cnt3;  logic done3, busy3, ovf3;
    logic [7:0]  sum4;  logic [7:0] cnt4;  logic done4, busy4, ovf4;

    sumitup_acc d0 (.ck(ck), .reset_l(reset_l), .go_l(go_l), .inA(inA), .ack(ack),
                    .sum(sum0), .done(done0), .busy(busy0), .count(cnt0), .ovf(ovf0));
    sumitup_acc #(.SUM_W(9)) d1 (.ck(ck), .reset_l(reset_l), .go_l(go_l), .inA(inA), .ack(ack),
                    .sum(sum1), .done(done1), .busy(busy1), .count(cnt1), .ovf(ovf1));
    sumitup_acc #(.SUM_W(9), .SATURATE(1'b0)) d2 (.ck(ck), .reset_l(reset_l), .go_l(go_l),
                    .inA(inA), .ack(ack),
                    .sum(sum2), .done(done2), .busy(busy2), .count(cnt2), .ovf(ovf2));
    sumitup_acc #(.MAX_CNT(4)) d3 (.ck(ck), .reset_l(reset_l), .go_l(go_l), .inA(inA), .ack(ack),
                    .sum(sum3), .done(done3), .busy(busy3), .count(cnt3), .ovf(ovf3));
    sumitup_acc #(.SUM_W(8), .SIGNED_IN(1'b1)) d4 (.ck(ck), .reset_l(reset_l), .go_l(go_l),
                    .inA(inA), .ack(ack),
                    .sum(sum4), .done(done4), .busy(busy4), .count(cnt4), .ovf(ovf4));

    int          sel;
    logic [15:0] sum_s;
    logic [7:0]  cnt_s;
    logic        done_s, busy_s, ovf_s;

    always_comb begin
        sum_s = sum0; cnt_s = cnt0; done_s = done0; busy_s = busy0; ovf_s = ovf0;
        case (sel)
            1: begin sum_s = 16'(sum1); cnt_s = cnt1; done_s = done1; busy_s = busy1; ovf_s = ovf1; end
            2: begin sum_s = 16'(sum2); cnt_s = cnt2; done_s = done2; busy_s = busy2; ovf_s = ovf2; end
            3: begin sum_s = sum3; cnt_s = 8'(cnt3); done_s = done3; busy_s = busy3; ovf_s = ovf3; end
            4: begin sum_s = 16'(sum4); cnt_s = cnt4; done_s = done4; busy_s = busy4; ovf_s = ovf4; end
            default: ;
        endcase
    end

    typedef struct {
        int              sel;
        logic [3:0][7:0] ops;
        int              nops;
        logic [15:0]     exp_sum;
        int              exp_cnt;
        bit              exp_ovf;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input logic [7:0] o0, input logic [7:0] o1,
                                input logic [7:0] o2, input logic [7:0] o3, input int n,
                                input logic [15:0] es, input int ec, input bit eo);
        vec_t v;
        v.sel = s; v.ops = {o3, o2, o1, o0}; v.nops = n;
        v.exp_sum = es; v.exp_cnt = ec; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge ck);
        reset_l = 1'b0; go_l = 1'b1; ack = 1'b0; inA = 8'h00;
        @(negedge ck);
        reset_l = 1'b1;
    endtask

    // Leaves the targeted DUT in HOLD, sampled at the negedge after the last edge.
    task automatic run_vec(input vec_t v, input int idx);
        do_reset();
        sel  = v.sel;
        go_l = 1'b0;
        @(negedge ck);
        go_l = 1'b1;
        for (int i = 0; i < v.nops; i++) begin
            inA = v.ops[i];
            @(negedge ck);
        end
        inA = 8'h00;
        check($sformatf("v%0d done", idx), 32'(done_s), 32'd1);
        check($sformatf("v%0d busy", idx), 32'(busy_s), 32'd0);
        check($sformatf("v%0d sum", idx), 32'(sum_s), 32'(v.exp_sum));
        check($sformatf("v%0d count", idx), 32'(cnt_s), 32'(v.exp_cnt));
        check($sformatf("v%0d ovf", idx), 32'(ovf_s), 32'(v.exp_ovf));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " sum"}, 32'(sum0), 32'd0);
        check({tag, " count"}, 32'(cnt0), 32'd0);
        check({tag, " done"}, 32'(done0), 32'd0);
        check({tag, " busy"}, 32'(busy0), 32'd0);
        check({tag, " ovf"}, 32'(ovf0), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        reset_l = 1'b1; go_l = 1'b1; ack = 1'b0; inA = 8'h00; sel = 0;

        vecs[0] = mk(0, 8'd3,   8'd5,   8'd7,   8'd0,  4, 16'd15,  3, 1'b0);
        vecs[1] = mk(1, 8'd255, 8'd255, 8'd255, 8'd0,  4, 16'd511, 3, 1'b1);
        vecs[2] = mk(2, 8'd255, 8'd255, 8'd255, 8'd0,  4, 16'd253, 3, 1'b1);
        vecs[3] = mk(3, 8'd1,   8'd1,   8'd1,   8'd1,  4, 16'd4,   4, 1'b0);
        vecs[4] = mk(4, 8'hFD,  8'h05,  8'h00,  8'h00, 3, 16'h02,  2, 1'b0);
        vecs[5] = mk(4, 8'h80,  8'hFF,  8'h00,  8'h00, 3, 16'h80,  2, 1'b1);
        vecs[6] = mk(4, 8'h7F,  8'h01,  8'hFF,  8'h00, 4, 16'h7E,  3, 1'b1);
        vecs[7] = mk(0, 8'h00,  8'h00,  8'h00,  8'h00, 1, 16'd0,   0, 1'b0);
        vecs[8] = mk(0, 8'hFF,  8'h01,  8'h00,  8'h00, 3, 16'd256, 2, 1'b0);

        // Asynchronous reset takes effect away from any clock edge
        #2 reset_l = 1'b0;
        #1 check_zero("reset");
        @(negedge ck);
        reset_l = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
            ack = 1'b1;
            @(negedge ck);
            ack = 1'b0;
        end

        // Result is held while ack stays low, even with go_l asserted
        run_vec(vecs[0], 100);
        for (int c = 0; c < 10; c++) begin
            go_l = c[0];
            @(negedge ck);
            check($sformatf("hold%0d done", c), 32'(done0), 32'd1);
            check($sformatf("hold%0d sum", c), 32'(sum0), 32'd15);
        end

        // Back-to-back: ack with go_l low restarts immediately
        ack = 1'b1; go_l = 1'b0;
        @(negedge ck);
        ack = 1'b0; go_l = 1'b1;
        check("b2b done", 32'(done0), 32'd0);
        check("b2b busy", 32'(busy0), 32'd1);
        check("b2b sum", 32'(sum0), 32'd0);
        check("b2b count", 32'(cnt0), 32'd0);
        inA = 8'd4;
        @(negedge ck);
        inA = 8'd0;
        @(negedge ck);
        check("b2b2 done", 32'(done0), 32'd1);
        check("b2b2 sum", 32'(sum0), 32'd4);
        check("b2b2 count", 32'(cnt0), 32'd1);

        // Plain ack returns to IDLE with the result still visible
        ack = 1'b1;
        @(negedge ck);
        ack = 1'b0;
        check("idle done", 32'(done0), 32'd0);
        check("idle busy", 32'(busy0), 32'd0);
        check("idle sum", 32'(sum0), 32'd4);
        check("idle count", 32'(cnt0), 32'd1);

        // Reset in the middle of a run
        go_l = 1'b0;
        @(negedge ck);
        go_l = 1'b1; inA = 8'd2;
        @(negedge ck);
        inA = 8'd3;
        @(negedge ck);
        check("mid busy", 32'(busy0), 32'd1);
        check("mid sum", 32'(sum0), 32'd5);
        check("mid count", 32'(cnt0), 32'd2);
        #2 reset_l = 1'b0;
        #1 check_zero("midrst");
        @(negedge ck);
        reset_l = 1'b1; inA = 8'd0;
        @(negedge ck);
        check("post-rst busy", 32'(busy0), 32'd0);
        go_l = 1'b0;
        @(negedge ck);
        go_l = 1'b1; inA = 8'd2;
        @(negedge ck);
        inA = 8'd0;
        @(negedge ck);
        check("rerun done", 32'(done0), 32'd1);
        check("rerun sum", 32'(sum0), 32'd2);
        check("rerun count", 32'(cnt0), 32'd1);
        check("rerun ovf", 32'(ovf0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
